// File: rtl/iob_eth_rx_frame_queue.sv
// Ethernet RX frame queue: stores up to NSLOTS complete frames from a byte stream in a slot ring
// and serves the head frame (length, bytes, pop) plus drop statistics to the host.
module iob_eth_rx_frame_queue #(
  parameter int NSLOTS      = 4,
  parameter int SLOT_ADDR_W = 11,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  input  logic              s_err,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              rx_ready
);

  localparam int PTR_W = $clog2(NSLOTS);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = SLOT_ADDR_W + 1;
  localparam logic [CNT_W-1:0] NSLOTS_C = CNT_W'(NSLOTS);
  localparam logic [LEN_W-1:0] MAX_LEN  = {1'b1, {SLOT_ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [31:0]       data_out_q, rd_data_s;
  logic              rx_ready_q;

  logic [7:0]        mem_q [NSLOTS * (2**SLOT_ADDR_W)];
  logic [LEN_W-1:0]  len_mem_q [NSLOTS];

  logic                   free_s, pop_s, clr_s, wr_en_s, commit_s, drop_inc_s;
  logic [SLOT_ADDR_W-1:0] wr_off_s;
  logic                   is_data_s, is_status_s, is_nbytes_s, is_pop_s;
  logic                   unused_data_in_s;

  assign unused_data_in_s = ^data_in;

  assign is_data_s   = addr[ADDR_W-1];
  assign is_status_s = (addr == ADDR_W'(0));
  assign is_nbytes_s = (addr == ADDR_W'(1));
  assign is_pop_s    = (addr == ADDR_W'(2));
  assign free_s      = (count_q < NSLOTS_C);
  assign pop_s       = sel & we & is_pop_s & (count_q != '0);
  assign clr_s       = sel & we & is_status_s;

  // Stream side: byte placement, commit/discard decisions and next FSM state
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_en_s    = 1'b0;
    wr_off_s   = '0;
    commit_s   = 1'b0;
    drop_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && free_s) begin
          wr_en_s = 1'b1;
          len_d   = LEN_W'(1);
          if (s_last) begin
            commit_s   = !s_err;
            drop_inc_s = s_err;
          end else begin
            state_d = RECV;
          end
        end else if (s_valid) begin
          if (s_last) drop_inc_s = 1'b1;
          else        state_d    = DROP;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (s_valid && (len_q == MAX_LEN)) begin
          // One byte past a full slot: the frame is oversize
          if (s_last) begin
            drop_inc_s = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (s_valid) begin
          wr_en_s  = 1'b1;
          wr_off_s = len_q[SLOT_ADDR_W-1:0];
          len_d    = len_q + LEN_W'(1);
          if (s_last) begin
            commit_s   = !s_err;
            drop_inc_s = s_err;
            state_d    = IDLE;
          end else begin
            state_d = RECV;
          end
        end else begin
          state_d = RECV;
        end
      end
      DROP: begin
        if (s_valid && s_last) begin
          drop_inc_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy, drop counter and host read mux
  always_comb begin
    case ({commit_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr_s)                                    drop_cnt_d = 16'h0000;
    else if (drop_inc_s && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    else                                          drop_cnt_d = drop_cnt_q;
    if (is_data_s)
      rd_data_s = {24'h000000, mem_q[{head_q, addr[SLOT_ADDR_W-1:0]}]};
    else if (is_status_s)
      rd_data_s = {drop_cnt_q, 8'(count_q), 6'b000000, (count_q == NSLOTS_C), (count_q != '0)};
    else if (is_nbytes_s && count_q != '0)
      rd_data_s = 32'(len_mem_q[head_q]);
    else
      rd_data_s = 32'h00000000;
  end

  // Control state, ring pointers and registered host outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      drop_cnt_q <= 16'h0000;
      data_out_q <= 32'h00000000;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      rx_ready_q <= (count_d != '0);
      if (commit_s) tail_q <= tail_q + PTR_W'(1);
      if (pop_s)    head_q <= head_q + PTR_W'(1);
      if (sel && !we) data_out_q <= rd_data_s;
    end
  end

  // Slot byte storage and committed lengths; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) mem_q[{tail_q, wr_off_s}] <= s_data;
    if (commit_s && !rst) len_mem_q[tail_q] <= len_d;
  end

  assign data_out = data_out_q;
  assign rx_ready = rx_ready_q;

endmodule

// File: tb/tb_iob_eth_rx_frame_queue.sv
// Bench for iob_eth_rx_frame_queue: directed vector table, corner sequences and a randomized
// phase checked against a frame-level queue model.
module tb_iob_eth_rx_frame_queue;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_last, s_err, sel, we, rx_ready;
  logic [7:0]  s_data;
  logic [11:0] addr;
  logic [31:0] data_in, data_out;

  int checks = 0;
  int failures = 0;

  localparam int OP_FRAME = 0, OP_READ = 1, OP_WRITE = 2;
  typedef struct {
    int          op;
    int          len;
    bit          err;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        rdy;
  } vec_t;
  vec_t vecs[$];

  // model: committed frame lengths, their bytes flattened in order, drop counter
  int          m_len[$];
  logic [7:0]  m_data[$];
  int          m_drop;
  logic [7:0]  fbytes[$];

  iob_eth_rx_frame_queue dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_err(s_err),
    .sel(sel), .we(we), .addr(addr), .data_in(data_in), .data_out(data_out), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic host_read(input logic [11:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = data_out;
  endtask

  task automatic host_write(input logic [11:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit err, input bit rnd, input bit pop_last,
                            input bit clr_last);
    fbytes.delete();
    for (int k = 0; k < len; k++) begin
      logic [7:0] b;
      if (rnd && $urandom_range(3) == 0) begin
        s_valid = 1'b0; s_last = 1'b1; s_err = 1'b1;
        @(negedge clk);
      end
      b = rnd ? 8'($urandom) : 8'(k);
      fbytes.push_back(b);
      s_valid = 1'b1; s_data = b; s_last = (k == len - 1);
      s_err = (k == len - 1) ? err : (rnd ? 1'($urandom) : 1'b0);
      if (k == len - 1 && (pop_last || clr_last)) begin
        sel = 1'b1; we = 1'b1; addr = pop_last ? 12'd2 : 12'd0; data_in = 32'h0;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0; sel = 1'b0; we = 1'b0;
  endtask

  task automatic model_frame(input int len, input bit err);
    if (m_len.size() >= 4 || err || len > 2048) begin
      if (m_drop < 65535) m_drop++;
    end else begin
      m_len.push_back(len);
      foreach (fbytes[k]) m_data.push_back(fbytes[k]);
    end
  endtask

  task automatic model_pop();
    if (m_len.size() > 0) begin
      for (int k = 0; k < m_len[0]; k++) void'(m_data.pop_front());
      void'(m_len.pop_front());
    end
  endtask

  function automatic logic [31:0] model_status();
    int n = m_len.size();
    return {16'(m_drop), 8'(n), 6'b000000, (n == 4), (n != 0)};
  endfunction

  function automatic void tf(input int len, input bit err);
    vecs.push_back('{OP_FRAME, len, err, 12'h0, 32'h0, 32'h0, 1'b0});
  endfunction
  function automatic void tr(input logic [11:0] a, input logic [31:0] exp, input logic rdy);
    vecs.push_back('{OP_READ, 0, 1'b0, a, 32'h0, exp, rdy});
  endfunction
  function automatic void tw(input logic [11:0] a, input logic [31:0] d);
    vecs.push_back('{OP_WRITE, 0, 1'b0, a, d, 32'h0, 1'b0});
  endfunction

  initial begin
    logic [31:0] rd;
    // directed table
    tr(12'h000, 32'h0, 1'b0); tr(12'h001, 32'h0, 1'b0); tr(12'h003, 32'h0, 1'b0);
    tw(12'h002, 32'h0); tr(12'h000, 32'h0, 1'b0);
    tf(64, 1'b0);
    tr(12'h000, 32'h101, 1'b1); tr(12'h001, 32'd64, 1'b1);
    tr(12'h805, 32'h05, 1'b1); tr(12'h83F, 32'h3F, 1'b1);
    tw(12'h003, 32'hFFFF); tr(12'h003, 32'h0, 1'b1);
    tw(12'h002, 32'h0); tr(12'h000, 32'h0, 1'b0);
    for (int l = 10; l <= 14; l++) tf(l, 1'b0);
    tr(12'h000, 32'h0001_0403, 1'b1); tr(12'h001, 32'd10, 1'b1); tr(12'h809, 32'h09, 1'b1);
    tw(12'h002, 32'h0); tr(12'h001, 32'd11, 1'b1);
    tw(12'h002, 32'h0); tr(12'h001, 32'd12, 1'b1);
    tw(12'h002, 32'h0); tr(12'h001, 32'd13, 1'b1);
    tw(12'h002, 32'h0); tr(12'h000, 32'h0001_0000, 1'b0); tr(12'h001, 32'h0, 1'b0);
    tw(12'h000, 32'h0); tr(12'h000, 32'h0, 1'b0);
    tf(7, 1'b1); tr(12'h000, 32'h0001_0000, 1'b0);
    tw(12'h000, 32'h1234); tr(12'h000, 32'h0, 1'b0);
    tf(2049, 1'b0); tr(12'h000, 32'h0001_0000, 1'b0); tw(12'h000, 32'h0);
    tf(2048, 1'b0); tr(12'h000, 32'h101, 1'b1); tr(12'h001, 32'd2048, 1'b1);
    tr(12'hFFF, 32'hFF, 1'b1); tr(12'h800, 32'h00, 1'b1); tw(12'h002, 32'h0);
    tf(1, 1'b0); tr(12'h001, 32'd1, 1'b1); tr(12'h800, 32'h00, 1'b1);
    tw(12'h002, 32'h0); tr(12'h000, 32'h0, 1'b0);

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0; s_err = 1'b0;
    sel = 1'b0; we = 1'b0; addr = 12'h0; data_in = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_data_out", data_out, 32'h0);
    check("reset_rx_ready", {31'h0, rx_ready}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_FRAME: send_frame(vecs[i].len, vecs[i].err, 1'b0, 1'b0, 1'b0);
        OP_WRITE: host_write(vecs[i].a, vecs[i].d);
        default: begin
          host_read(vecs[i].a, rd);
          check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
          check($sformatf("vec%0d_rx_ready", i), {31'h0, rx_ready}, {31'h0, vecs[i].rdy});
        end
      endcase
    end

    // commit and pop in the same cycle
    send_frame(5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(3, 1'b0, 1'b0, 1'b1, 1'b0);
    host_read(12'h000, rd); check("commit_pop_status", rd, 32'h101);
    host_read(12'h001, rd); check("commit_pop_nbytes", rd, 32'd3);
    host_read(12'h802, rd); check("commit_pop_data", rd, 32'h02);
    host_write(12'h002, 32'h0);

    // clear coinciding with an errored-frame drop
    send_frame(2, 1'b1, 1'b0, 1'b0, 1'b1);
    host_read(12'h000, rd); check("clear_vs_drop", rd, 32'h0);

    // reset in the middle of a frame
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1; s_data = 8'(k + 100); s_last = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_frame(30, 1'b0, 1'b0, 1'b0, 1'b0);
    host_read(12'h000, rd); check("rst_mid_status", rd, 32'h101);
    host_read(12'h001, rd); check("rst_mid_nbytes", rd, 32'd30);
    host_read(12'h800, rd); check("rst_mid_data0", rd, 32'h00);
    host_write(12'h002, 32'h0);

    // randomized phase against the frame-level model
    m_drop = 0;
    for (int it = 0; it < 200; it++) begin
      int sel_op = int'($urandom_range(99));
      if (sel_op < 40) begin
        int  len = int'($urandom_range(1, 40));
        bit  err = ($urandom_range(9) == 0);
        send_frame(len, err, 1'b1, 1'b0, 1'b0);
        model_frame(len, err);
      end else if (sel_op < 60) begin
        host_write(12'h002, $urandom);
        model_pop();
      end else if (sel_op < 65) begin
        host_write(12'h000, $urandom);
        m_drop = 0;
      end else if (sel_op < 75) begin
        host_read(12'h000, rd);
        check($sformatf("rnd%0d_status", it), rd, model_status());
      end else if (sel_op < 85) begin
        host_read(12'h001, rd);
        check($sformatf("rnd%0d_nbytes", it), rd, (m_len.size() > 0) ? 32'(m_len[0]) : 32'h0);
      end else if (m_len.size() > 0) begin
        int off = int'($urandom_range(m_len[0] - 1));
        host_read(12'h800 | 12'(off), rd);
        check($sformatf("rnd%0d_data", it), rd, {24'h0, m_data[off]});
      end else begin
        host_read(12'h000, rd);
        check($sformatf("rnd%0d_status_empty", it), rd, model_status());
      end
      check($sformatf("rnd%0d_rx_ready", it), {31'h0, rx_ready}, {31'h0, (m_len.size() != 0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
